// File: rtl/bit_rev_serializer_pkg.sv
// Shared types and helpers for the bit-reversing serializer.
package bit_rev_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XMIT = 1'b1
    } state_t;

    // Counter width for a word of nbits; never narrower than one bit.
    function automatic int cnt_width(input int nbits);
        return (nbits > 1) ? $clog2(nbits) : 1;
    endfunction

endpackage

// File: rtl/bit_rev_shift_reg.sv
// Loadable shift register; shifts toward the transmit end, zero-filled.
module bit_rev_shift_reg #(
    parameter int NBITS     = 100,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_shift_en,
    input  logic [NBITS-1:0] i_d,
    output logic [NBITS-1:0] o_q
);

    logic [NBITS-1:0] r_q;
    logic [NBITS-1:0] w_shifted;

    assign w_shifted = MSB_FIRST ? {r_q[NBITS-2:0], 1'b0} : {1'b0, r_q[NBITS-1:1]};
    assign o_q       = r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end else if (i_shift_en) begin
            r_q <= w_shifted;
        end
    end

endmodule

// File: rtl/bit_rev_serializer.sv
// Word-to-bit serializer on valid/ready links; a new word can load on the last bit's transfer.
//   state | meaning
//   IDLE  | no word held, ready for a new word
//   XMIT  | presenting bit r_cnt of the held word on out
module bit_rev_serializer
    import bit_rev_pkg::*;
#(
    parameter int NBITS     = 100,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NBITS-1:0] in_,
    input  logic             in_val,
    output logic             in_rdy,
    output logic             out,
    output logic             out_val,
    input  logic             out_rdy,
    output logic             out_last
);

    localparam int CW = cnt_width(NBITS);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [NBITS-1:0] w_q;
    logic             w_accept;
    logic             w_xfer;
    logic             w_shift;

    assign out_val  = (r_state == XMIT);
    assign out_last = out_val && (r_cnt == CW'(NBITS - 1));
    assign in_rdy   = (r_state == IDLE) || (out_last && out_rdy);
    assign w_accept = in_val && in_rdy;
    assign w_xfer   = out_val && out_rdy;
    // A load on the last transfer replaces the shift for that edge.
    assign w_shift  = w_xfer && !w_accept;
    assign out      = MSB_FIRST ? w_q[NBITS-1] : w_q[0];

    bit_rev_shift_reg #(
        .NBITS     (NBITS),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_accept),
        .i_shift_en (w_shift),
        .i_d        (in_),
        .o_q        (w_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_state <= XMIT;
            r_cnt   <= '0;
        end else if (w_xfer) begin
            if (out_last) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bit_rev_serializer.sv
// Randomized bench for bit_rev_serializer against a queue-based bit-stream model.
module tb_bit_rev_serializer;

    localparam int N  = 100;
    localparam int N8 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [N-1:0]  in_;
    logic          in_val, in_rdy, out, out_val, out_rdy, out_last;
    logic [N8-1:0] in8;
    logic          in_val8, in_rdy8, out8, out_val8, out_rdy8, out_last8;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;
    bit rdy_rand = 1'b0;

    bit_rev_serializer #(.NBITS(N), .MSB_FIRST(1'b1)) u_dut (
        .clk(clk), .reset(reset), .in_(in_), .in_val(in_val), .in_rdy(in_rdy),
        .out(out), .out_val(out_val), .out_rdy(out_rdy), .out_last(out_last)
    );

    bit_rev_serializer #(.NBITS(N8), .MSB_FIRST(1'b0)) u_dut8 (
        .clk(clk), .reset(reset), .in_(in8), .in_val(in_val8), .in_rdy(in_rdy8),
        .out(out8), .out_val(out_val8), .out_rdy(out_rdy8), .out_last(out_last8)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [N-1:0] rev100(input logic [N-1:0] w);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = w[N-1-i];
        return r;
    endfunction

    // Model: the bits still owed on each link, in transmit order.
    bit            q100[$];
    bit            q8[$];
    logic [N-1:0]  sent100[$];
    logic [N8-1:0] sent8[$];
    bit            acc100, acc8;

    always @(posedge clk) begin
        if (reset) begin
            q100.delete(); q8.delete(); sent100.delete(); sent8.delete();
        end else begin
            acc100 = in_val  && (q100.size() == 0 || (q100.size() == 1 && out_rdy));
            acc8   = in_val8 && (q8.size()   == 0 || (q8.size()   == 1 && out_rdy8));
            if (q100.size() != 0 && out_rdy)  void'(q100.pop_front());
            if (q8.size()   != 0 && out_rdy8) void'(q8.pop_front());
            if (acc100) begin
                for (int i = N - 1; i >= 0; i--) q100.push_back(in_[i]);
                sent100.push_back(in_);
            end
            if (acc8) begin
                for (int i = 0; i < N8; i++) q8.push_back(in8[i]);
                sent8.push_back(in8);
            end
        end
    end

    always begin
        @(posedge clk); #1;
        out_rdy  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        out_rdy8 = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Receiver, per-cycle compare and stall-stability tracking.
    logic [N-1:0]  rx_word, rx_last_word;
    logic [N8-1:0] rx8_word;
    int            rx_idx = 0, rx8_idx = 0, rx_words = 0;
    bit            rx8_bits[$];
    int            run_len = 0;
    int            runs[$];
    int            last_pos[$];
    bit            p_val, p_out, p_last, p_rdy, p_rst;
    bit            p_val8, p_out8, p_last8, p_rdy8;

    always @(negedge clk) begin
        if (started) begin
            chk("in_rdy100",  in_rdy,   q100.size() == 0 || (q100.size() == 1 && out_rdy));
            chk("out_val100", out_val,  q100.size() != 0);
            chk("out_last100", out_last, q100.size() == 1);
            chk("out100",     out,      (q100.size() != 0) ? q100[0] : 1'b0);
            chk("in_rdy8",    in_rdy8,  q8.size() == 0 || (q8.size() == 1 && out_rdy8));
            chk("out_val8",   out_val8, q8.size() != 0);
            chk("out_last8",  out_last8, q8.size() == 1);
            chk("out8",       out8,     (q8.size() != 0) ? q8[0] : 1'b0);

            if (p_val && !p_rdy && !p_rst) begin
                chk("stall_out100", {out_val, out, out_last}, {1'b1, p_out, p_last});
            end
            if (p_val8 && !p_rdy8 && !p_rst) begin
                chk("stall_out8", {out_val8, out8, out_last8}, {1'b1, p_out8, p_last8});
            end

            if (out_val) begin
                run_len++;
                if (out_last) last_pos.push_back(run_len);
            end else if (run_len > 0) begin
                runs.push_back(run_len);
                run_len = 0;
            end

            if (reset) begin
                rx_idx  = 0;
                rx8_idx = 0;
            end else begin
                if (out_val && out_rdy) begin
                    if (rx_idx < N) rx_word[rx_idx] = out;
                    rx_idx++;
                    if (out_last) begin
                        chk("word100_len", rx_idx, N);
                        if (sent100.size() == 0) chk("word100_sent", 0, 1);
                        else chk("word100_rev", rx_word, rev100(sent100.pop_front()));
                        rx_last_word = rx_word;
                        rx_words++;
                        rx_idx = 0;
                    end
                end
                if (out_val8 && out_rdy8) begin
                    if (rx8_idx < N8) rx8_word[rx8_idx] = out8;
                    rx8_bits.push_back(out8);
                    rx8_idx++;
                    if (out_last8) begin
                        chk("word8_len", rx8_idx, N8);
                        if (sent8.size() == 0) chk("word8_sent", 0, 1);
                        else chk("word8", rx8_word, sent8.pop_front());
                        rx8_idx = 0;
                    end
                end
            end
        end
        p_val  = out_val;  p_out  = out;  p_last  = out_last;  p_rdy  = out_rdy;
        p_val8 = out_val8; p_out8 = out8; p_last8 = out_last8; p_rdy8 = out_rdy8;
        p_rst  = reset;
    end

    task automatic send100(input logic [N-1:0] w, input bit keep);
        bit acc;
        int n = 0;
        in_    = w;
        in_val = 1'b1;
        do begin
            @(negedge clk); acc = in_rdy;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 5000);
        if (!acc) chk("send100_timeout", 0, 1);
        if (!keep) in_val = 1'b0;
    endtask

    task automatic send8(input logic [N8-1:0] w);
        bit acc;
        int n = 0;
        in8     = w;
        in_val8 = 1'b1;
        do begin
            @(negedge clk); acc = in_rdy8;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 5000);
        if (!acc) chk("send8_timeout", 0, 1);
        in_val8 = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((out_val || out_val8) && n < 5000);
        if (n >= 5000) chk("idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    function automatic logic [N-1:0] rand100();
        logic [N-1:0] w;
        for (int i = 0; i < N; i++) w[i] = 1'($urandom_range(0, 1));
        return w;
    endfunction

    initial begin
        logic [N-1:0] a5;
        logic [7:0]   pat;
        bit           exp_seq[8];
        int           words0;

        reset = 1'b1; in_ = '0; in_val = 1'b0; out_rdy = 1'b1;
        in8 = '0; in_val8 = 1'b0; out_rdy8 = 1'b1;
        @(posedge clk); #1; started = 1'b1;
        @(negedge clk);
        chk("rst_in_rdy", in_rdy, 1'b1);
        chk("rst_out_val", out_val, 1'b0);
        chk("rst_out", out, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        @(posedge clk); #1; reset = 1'b0;

        // Single set LSB comes out last and reassembles to bit 99.
        send100({{(N-1){1'b0}}, 1'b1}, 1'b0);
        wait_idle();
        chk("h1_reassembled", rx_last_word, {1'b1, {(N-1){1'b0}}});

        // A5 pattern and random words under random backpressure.
        pat = 8'hA5;
        for (int i = 0; i < N; i++) a5[i] = pat[i % 8];
        words0   = rx_words;
        rdy_rand = 1'b1;
        send100(a5, 1'b0);
        send100(a5, 1'b0);
        for (int k = 0; k < 3; k++) send100(rand100(), 1'b0);
        for (int k = 0; k < 4; k++) send8(8'($urandom));
        wait_idle();
        chk("rand_word_count", rx_words - words0, 5);
        rdy_rand = 1'b0;
        @(posedge clk); #1;

        // Back-to-back: two words, no bubble.
        runs.delete(); last_pos.delete();
        send100(100'h3, 1'b1);
        send100(100'hC, 1'b0);
        wait_idle();
        chk("b2b_run_len", (runs.size() > 0) ? runs[0] : -1, 200);
        chk("b2b_last_cnt", last_pos.size(), 2);
        chk("b2b_last_1", (last_pos.size() > 0) ? last_pos[0] : -1, 100);
        chk("b2b_last_2", (last_pos.size() > 1) ? last_pos[1] : -1, 200);

        // Reset while presenting bit 37.
        send100(rand100(), 1'b0);
        repeat (37) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_val", out_val, 1'b0);
        chk("midrst_in_rdy", in_rdy, 1'b1);
        @(posedge clk); #1; reset = 1'b0;
        send100(rand100(), 1'b0);
        wait_idle();

        // 8-bit LSB-first, with an ignored mid-word offer.
        exp_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        rx8_bits.delete();
        send8(8'hB4);
        repeat (3) begin @(posedge clk); #1; end
        in8 = 8'hFF; in_val8 = 1'b1;
        @(negedge clk);
        chk("b4_midword_in_rdy8", in_rdy8, 1'b0);
        @(posedge clk); #1; in_val8 = 1'b0;
        wait_idle();
        chk("b4_bit_count", rx8_bits.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("b4_bit%0d", i), (rx8_bits.size() > i) ? rx8_bits[i] : 1'bx, exp_seq[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
